// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and counter-width helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} uart_tx_state_t;
  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit)
  function automatic int ctr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-stage synchronizer for an asynchronous pad input
//   clk, rst : clock, asynchronous active-high reset (both stages load RST_VAL)
//   i_d      : asynchronous input
//   o_q      : synchronized output, two clocks behind i_d
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  always_ff @(posedge clk or posedge rst)
    if (rst) {o_q, r_meta} <= {2{RST_VAL}};
    else {o_q, r_meta} <= {r_meta, i_d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive engine with one-entry valid/ready holding register
//   clk, rst  : clock, asynchronous active-high reset
//   RX        : serial line, idle high, asynchronous to clk
//   R_W       : received word, valid while R_valid
//   R_valid   : holding register full; R_ready accepts it
//   R_locked  : frame reception in progress
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, word dropped because holding register was full
module uart_receiver
  import uart_pkg::*;
#(
  parameter int clk_reduction = 64,
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX,
  input  logic                  R_ready,
  output logic [word_width-1:0] R_W,
  output logic                  R_valid,
  output logic                  R_locked,
  output logic                  frame_err,
  output logic                  overrun
);
  localparam int CNT_W = ctr_width(clk_reduction);
  localparam int IDX_W = ctr_width(word_width + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(clk_reduction / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(clk_reduction - 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(word_width - 1);
  logic                  w_rxs;
  logic [word_width:0]   w_shift_in;
  uart_rx_state_t        r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [word_width-1:0] r_shift;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .i_d(RX), .o_q(w_rxs));
  // LSB-first: each new bit enters at the MSB and the word slides right
  assign w_shift_in = {w_rxs, r_shift};
  assign R_locked = r_state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      R_W       <= '0;
      R_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      r_cnt     <= r_cnt + CNT_W'(1);
      if (R_valid && R_ready) R_valid <= 1'b0;
      case (r_state)
        IDLE: if (!w_rxs) begin
          r_state <= START;
          r_cnt   <= '0;
        end
        START: if (r_cnt == HALF) begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_state <= w_rxs ? IDLE : DATA;
        end
        DATA: if (r_cnt == FULL) begin
          r_cnt   <= '0;
          r_shift <= w_shift_in[word_width:1];
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == LAST) r_state <= STOP;
        end
        // Stop is sampled mid-bit, so IDLE is reached half a bit early and a
        // back-to-back start edge is never missed
        STOP: if (r_cnt == FULL) begin
          r_cnt <= '0;
          if (!w_rxs) begin
            frame_err <= 1'b1;
            r_state   <= BREAK;
          end else begin
            r_state <= IDLE;
            if (!R_valid || R_ready) begin
              R_W     <= r_shift;
              R_valid <= 1'b1;
            end else overrun <= 1'b1;
          end
        end
        // A line held low after a bad stop bit must not look like a new start
        BREAK: if (w_rxs) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table-driven and scoreboard checks for uart_receiver
module tb_uart_receiver;
  localparam int N = 16;
  localparam int W = 8;
  logic clk = 1'b0, rst = 1'b1, RX = 1'b0, R_ready = 1'b0;
  logic [W-1:0] R_W;
  logic R_valid, R_locked, frame_err, overrun;
  int n_chk = 0, n_err = 0;
  int cyc = 0, n_del = 0, n_ferr = 0, n_ovr = 0;
  int del_cyc = -1, lock_rise = -1, lock_fall = -1;
  logic [W-1:0] exp_q[$];
  logic pv, pr, pl;

  uart_receiver #(.clk_reduction(N), .word_width(W)) dut (
    .clk(clk), .rst(rst), .RX(RX), .R_ready(R_ready), .R_W(R_W),
    .R_valid(R_valid), .R_locked(R_locked), .frame_err(frame_err), .overrun(overrun));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Delivery monitor: a word is delivered when R_valid rises, or stays high
  // across an edge where the previous word was accepted
  always @(posedge clk) begin
    pv = R_valid;
    pr = R_ready;
    pl = R_locked;
    #1;
    if (R_valid && (!pv || pr)) begin
      del_cyc = cyc;
      n_del++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_word: got 0x%0h expected none", R_W);
      end else chk("word", int'(R_W), int'(exp_q.pop_front()));
    end
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (R_locked && !pl) lock_rise = cyc;
    if (!R_locked && pl) lock_fall = cyc;
  end

  // Drives ncyc clocks of a frame starting at a negedge; optionally raises
  // R_ready for exactly the delivery edge (fall + 3 + N/2 + 9N)
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input bit pulse, input int ncyc);
    logic [W+1:0] bits;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      RX = bits[c / N];
      if (pulse) R_ready = (c == 3 + N / 2 + (W + 1) * N - 1);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] d;
    logic stop;
    int exp_del;
    int exp_ferr;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int c0, d0, f0, o0;
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h01, 1'b1, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b0, 0, 1};
    vecs[5] = '{8'h96, 1'b1, 1, 0};

    // Reset with RX low: everything quiet
    repeat (4) @(negedge clk);
    chk("rst_R_W", int'(R_W), 0);
    chk("rst_R_valid", int'(R_valid), 0);
    chk("rst_R_locked", int'(R_locked), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    RX = 1'b1;
    rst = 1'b0;
    idle(20);
    chk("rel_R_locked", int'(R_locked), 0);
    chk("rel_no_delivery", n_del, 0);

    // Single frame with latency and lock timing
    c0 = cyc;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, (W + 2) * N);
    chk("single_latency", del_cyc - c0, 3 + N / 2 + (W + 1) * N);
    chk("single_lock_rise", lock_rise - c0, 3);
    chk("single_lock_fall", lock_fall, del_cyc);
    chk("single_R_valid", int'(R_valid), 1);
    chk("single_R_W", int'(R_W), 'hA5);
    chk("single_no_ferr", n_ferr, 0);
    chk("single_no_ovr", n_ovr, 0);
    R_ready = 1'b1;
    @(negedge clk);
    R_ready = 1'b0;
    chk("accept_drop", int'(R_valid), 0);
    chk("hold_R_W", int'(R_W), 'hA5);

    // Glitch: 4 clocks low
    d0 = n_del; f0 = n_ferr; c0 = cyc;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    chk("glitch_locked_pulse", lock_rise - c0, 3);
    chk("glitch_unlocked", int'(R_locked), 0);
    chk("glitch_no_delivery", n_del - d0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);

    // Framing error followed by held-low line
    d0 = n_del; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, (W + 2) * N);
    RX = 1'b0;
    repeat (40) @(negedge clk);
    chk("ferr_pulse", n_ferr - f0, 1);
    chk("ferr_no_delivery", n_del - d0, 0);
    chk("ferr_break_locked", int'(R_locked), 1);
    idle(5);
    chk("ferr_break_exit", int'(R_locked), 0);

    // Overrun: second word dropped
    o0 = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, (W + 2) * N);
    idle(5);
    send_frame(8'h22, 1'b1, 1'b0, (W + 2) * N);
    chk("ovr_pulse", n_ovr - o0, 1);
    chk("ovr_keep_word", int'(R_W), 'h11);
    chk("ovr_valid", int'(R_valid), 1);
    R_ready = 1'b1;
    @(negedge clk);
    R_ready = 1'b0;
    chk("ovr_drain", int'(R_valid), 0);

    // Accept on the exact delivery cycle: no overrun, new word loaded
    o0 = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, (W + 2) * N);
    idle(5);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, 1'b1, (W + 2) * N);
    chk("sim_no_ovr", n_ovr - o0, 0);
    chk("sim_R_W", int'(R_W), 'h22);
    chk("sim_valid", int'(R_valid), 1);
    R_ready = 1'b1;
    idle(3);

    // Table of frames with consumer always ready
    foreach (vecs[i]) begin
      d0 = n_del; f0 = n_ferr;
      if (vecs[i].exp_del != 0) exp_q.push_back(vecs[i].d);
      send_frame(vecs[i].d, vecs[i].stop, 1'b0, (W + 2) * N);
      idle(20);
      chk($sformatf("vec%0d_delivered", i), n_del - d0, vecs[i].exp_del);
      chk($sformatf("vec%0d_ferr", i), n_ferr - f0, vecs[i].exp_ferr);
      chk($sformatf("vec%0d_idle", i), int'(R_locked), 0);
    end

    // Back-to-back frames, no idle gap
    d0 = n_del; f0 = n_ferr;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h5A);
    send_frame(8'h00, 1'b1, 1'b0, (W + 2) * N);
    send_frame(8'hFF, 1'b1, 1'b0, (W + 2) * N);
    send_frame(8'h5A, 1'b1, 1'b0, (W + 2) * N);
    idle(5);
    chk("b2b_count", n_del - d0, 3);
    chk("b2b_no_ferr", n_ferr - f0, 0);

    // Reset during data bit 4, then a clean frame
    d0 = n_del;
    send_frame(8'hC3, 1'b1, 1'b0, N + 4 * N + N / 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(200);
    chk("midrst_no_delivery", n_del - d0, 0);
    chk("midrst_R_valid", int'(R_valid), 0);
    chk("midrst_R_W", int'(R_W), 0);
    chk("midrst_locked", int'(R_locked), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, (W + 2) * N);
    idle(5);
    chk("midrst_next_frame", n_del - d0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
